// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates LSB loads/stores over ICache refills onto
// a single byte-wide RAM port, assembling/disassembling little-endian words.
module mem_ctrl (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        io_buffer_full,
   input  logic        clear,
   input  logic        if_need,
   input  logic [31:0] if_addr,
   output logic [31:0] if_ins,
   output logic        if_ins_ready,
   input  logic        ls_need,
   input  logic        ls_wr,
   input  logic [1:0]  ls_len,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic [31:0] ls_rdata,
   output logic        ls_ready
);

   typedef enum logic [1:0] {IDLE, LS_RD, LS_WR, IF_RD} state_t;

   state_t      state_q;
   logic [2:0]  cnt_q;
   logic [2:0]  len_q;
   logic [31:0] base_q;
   logic [31:0] wdata_q;
   logic [31:0] data_q;
   logic        rdy_prev_q;
   logic [7:0]  din_q;

   logic [31:0] cur_addr;
   logic        io_stall;
   logic        grant_block;
   logic [7:0]  din_eff;
   logic [7:0]  wr_byte;
   logic [31:0] rd_data_d;

   function automatic logic [2:0] byte_count(input logic [1:0] len);
      case (len)
         2'd0:    return 3'd1;
         2'd1:    return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   assign grant_block = if_ins_ready | ls_ready;

   // Byte addressing, IO stall detection and read-data assembly for the current byte.
   always_comb begin
      cur_addr  = base_q + {29'd0, cnt_q};
      io_stall  = (cur_addr[17:16] == 2'b11) && io_buffer_full;
      din_eff   = rdy_prev_q ? mem_din : din_q;
      rd_data_d = data_q;
      case (cnt_q)
         3'd1:    rd_data_d[7:0]   = din_eff;
         3'd2:    rd_data_d[15:8]  = din_eff;
         3'd3:    rd_data_d[23:16] = din_eff;
         3'd4:    rd_data_d[31:24] = din_eff;
         default: rd_data_d        = data_q;
      endcase
      case (cnt_q[1:0])
         2'd0:    wr_byte = wdata_q[7:0];
         2'd1:    wr_byte = wdata_q[15:8];
         2'd2:    wr_byte = wdata_q[23:16];
         default: wr_byte = wdata_q[31:24];
      endcase
   end

   // RAM data arrives one cycle after its address, so the byte that landed on the first
   // frozen edge is kept and used when the controller resumes.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         rdy_prev_q <= 1'b1;
         din_q      <= 8'd0;
      end else begin
         rdy_prev_q <= rdy_in;
         din_q      <= din_eff;
      end
   end

   // Arbitration, transaction sequencing and all registered outputs.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q      <= IDLE;
         cnt_q        <= 3'd0;
         len_q        <= 3'd0;
         base_q       <= 32'd0;
         wdata_q      <= 32'd0;
         data_q       <= 32'd0;
         mem_a        <= 32'd0;
         mem_dout     <= 8'd0;
         mem_wr       <= 1'b0;
         if_ins       <= 32'd0;
         if_ins_ready <= 1'b0;
         ls_rdata     <= 32'd0;
         ls_ready     <= 1'b0;
      end else if (rdy_in) begin
         if_ins_ready <= 1'b0;
         ls_ready     <= 1'b0;
         case (state_q)
            IDLE: begin
               mem_wr <= 1'b0;
               if (!grant_block && ls_need) begin
                  base_q  <= ls_addr;
                  len_q   <= byte_count(ls_len);
                  wdata_q <= ls_wdata;
                  data_q  <= 32'd0;
                  mem_a   <= ls_addr;
                  if (ls_wr) begin
                     state_q <= LS_WR;
                     if ((ls_addr[17:16] == 2'b11) && io_buffer_full) begin
                        cnt_q <= 3'd0;
                     end else begin
                        mem_wr   <= 1'b1;
                        mem_dout <= ls_wdata[7:0];
                        cnt_q    <= 3'd1;
                     end
                  end else begin
                     state_q <= LS_RD;
                     cnt_q   <= 3'd0;
                  end
               end else if (!grant_block && if_need && !clear) begin
                  state_q <= IF_RD;
                  base_q  <= if_addr;
                  len_q   <= 3'd4;
                  data_q  <= 32'd0;
                  mem_a   <= if_addr;
                  cnt_q   <= 3'd0;
               end
            end
            LS_RD, IF_RD: begin
               if ((state_q == IF_RD) && clear) begin
                  state_q <= IDLE;
                  cnt_q   <= 3'd0;
               end else if (cnt_q == len_q) begin
                  state_q <= IDLE;
                  cnt_q   <= 3'd0;
                  data_q  <= rd_data_d;
                  if (state_q == IF_RD) begin
                     if_ins       <= rd_data_d;
                     if_ins_ready <= 1'b1;
                  end else begin
                     ls_rdata <= rd_data_d;
                     ls_ready <= 1'b1;
                  end
               end else begin
                  data_q <= rd_data_d;
                  cnt_q  <= cnt_q + 3'd1;
                  if ((cnt_q + 3'd1) < len_q) begin
                     mem_a <= cur_addr + 32'd1;
                  end
               end
            end
            LS_WR: begin
               if (cnt_q == len_q) begin
                  state_q  <= IDLE;
                  cnt_q    <= 3'd0;
                  mem_wr   <= 1'b0;
                  ls_ready <= 1'b1;
               end else if (io_stall) begin
                  mem_wr <= 1'b0;
               end else begin
                  mem_wr   <= 1'b1;
                  mem_a    <= cur_addr;
                  mem_dout <= wr_byte;
                  cnt_q    <= cnt_q + 3'd1;
               end
            end
            default: begin
               state_q <= IDLE;
               mem_wr  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed + randomized bench for mem_ctrl with a byte-array RAM and a shadow reference memory.
module tb_mem_ctrl;

   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in;
   logic [7:0]  mem_din, mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr, io_buffer_full, clear;
   logic        if_need, if_ins_ready, ls_need, ls_wr, ls_ready;
   logic [31:0] if_addr, if_ins, ls_addr, ls_wdata, ls_rdata;
   logic [1:0]  ls_len;

   int checks = 0;
   int failures = 0;

   logic [7:0] ram     [0:4095];
   logic [7:0] ref_mem [0:4095];
   logic       ram_init;

   mem_ctrl dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full), .clear(clear),
      .if_need(if_need), .if_addr(if_addr), .if_ins(if_ins), .if_ins_ready(if_ins_ready),
      .ls_need(ls_need), .ls_wr(ls_wr), .ls_len(ls_len), .ls_addr(ls_addr),
      .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_ready(ls_ready)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [7:0] init_byte(input int unsigned i);
      logic [31:0] h;
      h = i * 32'h9E37_79B1 + 32'h1234_5678;
      return h[31:24];
   endfunction

   // RAM: registered read, one-cycle latency; aliased to 4 KiB
   always @(posedge clk_in) begin
      if (ram_init) begin
         for (int i = 0; i < 4096; i++) ram[i] <= init_byte(i);
      end else begin
         mem_din <= ram[mem_a[11:0]];
         if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
      end
   end

   function automatic int bytes_of(input logic [1:0] len);
      return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_mem_a"}, mem_a, 32'd0);
      chk({tag, "_mem_dout"}, {24'd0, mem_dout}, 32'd0);
      chk({tag, "_mem_wr"}, {31'd0, mem_wr}, 32'd0);
      chk({tag, "_if_ins"}, if_ins, 32'd0);
      chk({tag, "_ls_rdata"}, ls_rdata, 32'd0);
      chk({tag, "_if_rdy"}, {31'd0, if_ins_ready}, 32'd0);
      chk({tag, "_ls_rdy"}, {31'd0, ls_ready}, 32'd0);
   endtask

   // kind: 0 = fetch, 1 = load, 2 = store. Starts in cycle 0 with the controller idle.
   task automatic do_txn(input int kind, input logic [31:0] addr, input logic [1:0] len,
                         input logic [31:0] wdata, output logic [31:0] got);
      int n, lat;
      logic [31:0] expd, a;
      logic rdy, other;
      n    = (kind == 0) ? 4 : bytes_of(len);
      lat  = (kind == 2) ? n + 1 : n + 2;
      expd = 32'd0;
      got  = 32'd0;
      for (int k = 0; k < n; k++) begin
         a = addr + 32'(k);
         if (kind == 2) ref_mem[a[11:0]] = wdata[8*k +: 8];
         else expd[8*k +: 8] = ref_mem[a[11:0]];
      end
      if (kind == 0) begin
         if_need = 1'b1; if_addr = addr;
      end else begin
         ls_need = 1'b1; ls_wr = (kind == 2); ls_len = len; ls_addr = addr; ls_wdata = wdata;
      end
      for (int c = 1; c <= lat; c++) begin
         tick();
         rdy   = (kind == 0) ? if_ins_ready : ls_ready;
         other = (kind == 0) ? ls_ready : if_ins_ready;
         if (c == lat) begin
            chk("ready_pulse", {31'd0, rdy}, 32'd1);
            chk("other_ready", {31'd0, other}, 32'd0);
            if (kind != 2) begin
               got = (kind == 0) ? if_ins : ls_rdata;
               chk("read_data", got, expd);
            end else begin
               chk("wr_done_idle", {31'd0, mem_wr}, 32'd0);
            end
            if_need = 1'b0;
            ls_need = 1'b0;
         end else begin
            chk("early_ready", {31'd0, rdy}, 32'd0);
            a = addr + 32'(c - 1);
            if (kind == 2) begin
               chk("wr_en", {31'd0, mem_wr}, 32'd1);
               chk("wr_addr", mem_a, a);
               chk("wr_data", {24'd0, mem_dout}, {24'd0, wdata[8*(c-1) +: 8]});
            end else if (c <= n) begin
               chk("rd_addr", mem_a, a);
               chk("rd_nowr", {31'd0, mem_wr}, 32'd0);
            end
         end
      end
      tick();
      chk("ready_drop", {31'd0, (kind == 0) ? if_ins_ready : ls_ready}, 32'd0);
   endtask

   initial begin
      logic [31:0] got, expf, a;
      logic [7:0]  before42;
      int          bad, kind;
      logic [31:0] raddr, rdat;
      logic [1:0]  rlen;

      rst_in = 1'b1; ram_init = 1'b1; rdy_in = 1'b1;
      io_buffer_full = 1'b0; clear = 1'b0;
      if_need = 1'b0; if_addr = 32'd0;
      ls_need = 1'b0; ls_wr = 1'b0; ls_len = 2'd0; ls_addr = 32'd0; ls_wdata = 32'd0;
      for (int i = 0; i < 4096; i++) ref_mem[i] = init_byte(i);
      tick(); tick();
      chk_all_zero("reset");
      ram_init = 1'b0;
      rst_in   = 1'b0;
      tick();
      chk_all_zero("post_reset");

      // preload the test-plan bytes through the controller
      do_txn(2, 32'h0000_0100, 2'd2, 32'h00A0_0513, got);
      do_txn(2, 32'h0000_0020, 2'd0, 32'h0000_00FF, got);

      do_txn(0, 32'h0000_0100, 2'd0, 32'd0, got);
      chk("fetch_const", got, 32'h00A0_0513);

      // simultaneous requests: load wins, fetch follows after the guard cycle
      ls_need = 1'b1; ls_wr = 1'b0; ls_len = 2'd0; ls_addr = 32'h20;
      if_need = 1'b1; if_addr = 32'h100;
      tick(); chk("sim_a1", mem_a, 32'h20);
      tick();
      tick(); chk("sim_ls_rdy", {31'd0, ls_ready}, 32'd1);
              chk("sim_ls_data", ls_rdata, 32'h0000_00FF);
              chk("sim_if_rdy3", {31'd0, if_ins_ready}, 32'd0);
      ls_need = 1'b0;
      tick(); chk("sim_guard_a4", mem_a, 32'h20);
      for (int c = 5; c <= 8; c++) begin
         tick(); chk("sim_fetch_addr", mem_a, 32'h100 + 32'(c - 5));
      end
      tick();
      tick(); chk("sim_if_rdy10", {31'd0, if_ins_ready}, 32'd1);
              chk("sim_if_data", if_ins, 32'h00A0_0513);
      if_need = 1'b0;
      tick();

      before42 = ref_mem[12'h042];
      do_txn(2, 32'h0000_0040, 2'd1, 32'hDEAD_BEEF, got);
      chk("hs_ram40", {24'd0, ram[12'h040]}, 32'h0000_00EF);
      chk("hs_ram41", {24'd0, ram[12'h041]}, 32'h0000_00BE);
      chk("hs_ram42", {24'd0, ram[12'h042]}, {24'd0, before42});

      // IO store stalled by a full UART buffer on the edges launching cycles 2 and 3
      ls_need = 1'b1; ls_wr = 1'b1; ls_len = 2'd2; ls_addr = 32'h0003_0000; ls_wdata = 32'h1122_3344;
      for (int k = 0; k < 4; k++) ref_mem[k] = ls_wdata[8*k +: 8];
      tick(); chk("io_c1_wr", {31'd0, mem_wr}, 32'd1);
              chk("io_c1_a", mem_a, 32'h0003_0000);
              chk("io_c1_d", {24'd0, mem_dout}, 32'h44);
      io_buffer_full = 1'b1;
      tick(); chk("io_c2_stall", {31'd0, mem_wr}, 32'd0);
      tick(); chk("io_c3_stall", {31'd0, mem_wr}, 32'd0);
              chk("io_c3_rdy", {31'd0, ls_ready}, 32'd0);
      io_buffer_full = 1'b0;
      for (int c = 4; c <= 6; c++) begin
         tick(); chk("io_wr", {31'd0, mem_wr}, 32'd1);
                 chk("io_a", mem_a, 32'h0003_0000 + 32'(c - 3));
                 chk("io_d", {24'd0, mem_dout}, {24'd0, ls_wdata[8*(c-3) +: 8]});
                 chk("io_early_rdy", {31'd0, ls_ready}, 32'd0);
      end
      tick(); chk("io_c7_rdy", {31'd0, ls_ready}, 32'd1);
      ls_need = 1'b0;
      tick(); chk("io_rdy_drop", {31'd0, ls_ready}, 32'd0);

      // flush in cycle 3 of a fetch, then a fresh fetch from 0x200
      expf = {ref_mem[12'h203], ref_mem[12'h202], ref_mem[12'h201], ref_mem[12'h200]};
      if_need = 1'b1; if_addr = 32'h100;
      tick(); chk("fl_a1", mem_a, 32'h100);
      tick();
      tick(); clear = 1'b1;
      tick(); chk("fl_c4_rdy", {31'd0, if_ins_ready}, 32'd0);
      clear = 1'b0; if_addr = 32'h200;
      tick(); chk("fl_new_a", mem_a, 32'h200);
      for (int c = 6; c <= 9; c++) begin
         tick(); chk("fl_no_rdy", {31'd0, if_ins_ready}, 32'd0);
      end
      tick(); chk("fl_rdy", {31'd0, if_ins_ready}, 32'd1);
              chk("fl_data", if_ins, expf);
      if_need = 1'b0;
      tick();

      // freeze for three edges mid-fetch, then freeze again while the pulse is up
      if_need = 1'b1; if_addr = 32'h100;
      tick(); chk("fz_a1", mem_a, 32'h100);
      tick(); chk("fz_a2", mem_a, 32'h101);
      tick(); chk("fz_a3", mem_a, 32'h102);
      rdy_in = 1'b0;
      tick(); chk("fz_a4", mem_a, 32'h102);
      tick(); chk("fz_a5", mem_a, 32'h102);
      tick(); chk("fz_a6", mem_a, 32'h102);
      rdy_in = 1'b1;
      tick(); chk("fz_a7", mem_a, 32'h103);
      tick(); chk("fz_c8_rdy", {31'd0, if_ins_ready}, 32'd0);
      tick(); chk("fz_c9_rdy", {31'd0, if_ins_ready}, 32'd1);
              chk("fz_data", if_ins, 32'h00A0_0513);
      if_need = 1'b0; rdy_in = 1'b0;
      tick(); chk("fz_hold10", {31'd0, if_ins_ready}, 32'd1);
      tick(); chk("fz_hold11", {31'd0, if_ins_ready}, 32'd1);
      rdy_in = 1'b1;
      tick(); chk("fz_drop12", {31'd0, if_ins_ready}, 32'd0);

      // asynchronous reset in the middle of a word load
      ls_need = 1'b1; ls_wr = 1'b0; ls_len = 2'd2; ls_addr = 32'h300;
      tick(); tick(); tick();
      rst_in = 1'b1;
      #1;
      chk_all_zero("midrst");
      #1;
      rst_in = 1'b0; ls_need = 1'b0;
      for (int c = 0; c < 8; c++) begin
         tick(); chk("midrst_no_rdy", {31'd0, ls_ready}, 32'd0);
      end

      do_txn(1, 32'hFFFF_FFFE, 2'd2, 32'd0, got);
      do_txn(1, 32'h0000_0150, 2'd3, 32'd0, got);

      for (int t = 0; t < 40; t++) begin
         kind  = int'($urandom_range(0, 2));
         raddr = $urandom;
         rdat  = $urandom;
         rlen  = 2'($urandom_range(0, 3));
         if (kind == 2) raddr[17:16] = 2'b00;
         do_txn(kind, raddr, rlen, rdat, got);
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
      end

      bad = 0;
      for (int i = 0; i < 4096; i++) if (ram[i] !== ref_mem[i]) bad++;
      chk("ram_image", 32'(bad), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
